alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 191 +++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle logic/arith/shift ops plus 32-iteration
// shift-add multiply and restoring divide into HI/LO.
//
//  state | meaning
//  IDLE  | waits for start; single-cycle ops complete here
//  MUL   | one shift-add step per cycle, busy high
//  DIV   | one restoring-division step per cycle, busy high
//  DONE  | sign-correct, write HI/LO, pulse done
module alu_exec_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  aLUControl,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    input  logic [4:0]  shamt,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        zero,
    output logic        overflow,
    output logic        divByZero,
    output logic        illegalOp
);
    localparam logic [4:0] OP_AND   = 5'd0;
    localparam logic [4:0] OP_OR    = 5'd1;
    localparam logic [4:0] OP_ADD   = 5'd2;
    localparam logic [4:0] OP_SUB   = 5'd3;
    localparam logic [4:0] OP_SLT   = 5'd4;
    localparam logic [4:0] OP_NOR   = 5'd5;
    localparam logic [4:0] OP_XOR   = 5'd6;
    localparam logic [4:0] OP_SLL   = 5'd7;
    localparam logic [4:0] OP_SRL   = 5'd8;
    localparam logic [4:0] OP_SRA   = 5'd9;
    localparam logic [4:0] OP_LUI   = 5'd10;
    localparam logic [4:0] OP_MULT  = 5'd11;
    localparam logic [4:0] OP_MULTU = 5'd12;
    localparam logic [4:0] OP_DIV   = 5'd13;
    localparam logic [4:0] OP_DIVU  = 5'd14;
    localparam logic [4:0] OP_MFHI  = 5'd15;
    localparam logic [4:0] OP_MFLO  = 5'd16;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t      r_state;
    logic [4:0]  r_cnt;
    logic [63:0] r_acc;
    logic [31:0] r_opb;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_neg_lo;
    logic        r_neg_hi;
    logic        r_is_div;
    logic        r_arm;

    logic [31:0] w_sum;
    logic [31:0] w_diff;
    logic [31:0] w_alu_res;
    logic        w_alu_ovf;
    logic        w_illegal;
    logic        w_is_mul;
    logic        w_is_div;
    logic        w_signed;
    logic [31:0] w_mag_a;
    logic [31:0] w_mag_b;
    logic [32:0] w_mul_sum;
    logic [32:0] w_div_trial;
    logic [63:0] w_prod;
    logic [31:0] w_fin_hi;
    logic [31:0] w_fin_lo;

    always_comb begin
        w_sum     = operandA + operandB;
        w_diff    = operandA - operandB;
        w_alu_res = 32'd0;
        w_alu_ovf = 1'b0;
        w_illegal = 1'b0;
        case (aLUControl)
            OP_AND:  w_alu_res = operandA & operandB;
            OP_OR:   w_alu_res = operandA | operandB;
            OP_ADD: begin
                w_alu_res = w_sum;
                w_alu_ovf = (operandA[31] == operandB[31]) && (w_sum[31] != operandA[31]);
            end
            OP_SUB: begin
                w_alu_res = w_diff;
                w_alu_ovf = (operandA[31] != operandB[31]) && (w_diff[31] != operandA[31]);
            end
            OP_SLT:  w_alu_res = {31'd0, ($signed(operandA) < $signed(operandB))};
            OP_NOR:  w_alu_res = ~(operandA | operandB);
            OP_XOR:  w_alu_res = operandA ^ operandB;
            OP_SLL:  w_alu_res = operandB << shamt;
            OP_SRL:  w_alu_res = operandB >> shamt;
            OP_SRA:  w_alu_res = $signed(operandB) >>> shamt;
            OP_LUI:  w_alu_res = {operandB[15:0], 16'h0000};
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: w_alu_res = 32'd0;
            OP_MFHI: w_alu_res = r_hi;
            OP_MFLO: w_alu_res = r_lo;
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_is_mul = (aLUControl == OP_MULT) || (aLUControl == OP_MULTU);
    assign w_is_div = (aLUControl == OP_DIV)  || (aLUControl == OP_DIVU);
    assign w_signed = (aLUControl == OP_MULT) || (aLUControl == OP_DIV);
    assign w_mag_a  = (w_signed && operandA[31]) ? (32'd0 - operandA) : operandA;
    assign w_mag_b  = (w_signed && operandB[31]) ? (32'd0 - operandB) : operandB;

    // r_acc holds {partial product, multiplier} or {remainder, dividend/quotient}
    assign w_mul_sum   = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_opb : 32'd0)};
    assign w_div_trial = {r_acc[63:32], r_acc[31]} - {1'b0, r_opb};
    assign w_prod      = r_neg_lo ? (64'd0 - r_acc) : r_acc;
    assign w_fin_lo    = r_is_div ? (r_neg_lo ? (32'd0 - r_acc[31:0]) : r_acc[31:0]) : w_prod[31:0];
    assign w_fin_hi    = r_is_div ? (r_neg_hi ? (32'd0 - r_acc[63:32]) : r_acc[63:32]) : w_prod[63:32];

    // r_arm blocks the first edge after reset release, so a start raised
    // together with the release never launches an op.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= 5'd0;
            r_acc     <= 64'd0;
            r_opb     <= 32'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_neg_lo  <= 1'b0;
            r_neg_hi  <= 1'b0;
            r_is_div  <= 1'b0;
            r_arm     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= 32'd0;
            zero      <= 1'b1;
            overflow  <= 1'b0;
            divByZero <= 1'b0;
            illegalOp <= 1'b0;
        end else begin
            done  <= 1'b0;
            r_arm <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (start && r_arm) begin
                        if (w_is_mul || (w_is_div && (operandB != 32'd0))) begin
                            r_acc    <= {32'd0, w_mag_a};
                            r_opb    <= w_mag_b;
                            r_is_div <= w_is_div;
                            r_neg_lo <= w_signed && (operandA[31] ^ operandB[31]);
                            r_neg_hi <= w_signed && operandA[31];
                            r_cnt    <= 5'd31;
                            busy     <= 1'b1;
                            r_state  <= w_is_div ? S_DIV : S_MUL;
                        end else begin
                            result    <= w_alu_res;
                            zero      <= (w_alu_res == 32'd0);
                            overflow  <= w_alu_ovf;
                            divByZero <= w_is_div;
                            illegalOp <= w_illegal;
                            done      <= 1'b1;
                        end
                    end
                end
                S_MUL, S_DIV: begin
                    if (r_state == S_MUL)
                        r_acc <= {w_mul_sum, r_acc[31:1]};
                    else if (!w_div_trial[32])
                        r_acc <= {w_div_trial[31:0], r_acc[30:0], 1'b1};
                    else
                        r_acc <= {r_acc[62:0], 1'b0};
                    if (r_cnt == 5'd0) begin
                        busy    <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 5'd1;
                    end
                end
                S_DONE: begin
                    r_hi      <= w_fin_hi;
                    r_lo      <= w_fin_lo;
                    result    <= w_fin_lo;
                    zero      <= (w_fin_lo == 32'd0);
                    overflow  <= 1'b0;
                    divByZero <= 1'b0;
                    illegalOp <= 1'b0;
                    done      <= 1'b1;
                    r_state   <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: arithmetic reference model checked
// every cycle, plus hand-computed literal expectations.
module tb_alu_exec_unit;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  aLUControl = 5'd0;
    logic [31:0] operandA = 32'd0;
    logic [31:0] operandB = 32'd0;
    logic [4:0]  shamt = 5'd0;
    logic        start = 1'b0;
    logic        busy, done, zero, overflow, divByZero, illegalOp;
    logic [31:0] result;

    alu_exec_unit dut (
        .clk(clk), .reset_n(reset_n), .aLUControl(aLUControl),
        .operandA(operandA), .operandB(operandB), .shamt(shamt), .start(start),
        .busy(busy), .done(done), .result(result), .zero(zero),
        .overflow(overflow), .divByZero(divByZero), .illegalOp(illegalOp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // model-visible state (what the outputs must currently show)
    logic [31:0] m_hi = 32'd0, m_lo = 32'd0, m_result = 32'd0;
    logic        m_zero = 1'b1, m_ovf = 1'b0, m_dbz = 1'b0, m_ill = 1'b0, m_done = 1'b0;
    // pending operation
    bit          pend = 1'b0;
    logic        e_multi = 1'b0;
    int          e_e0 = 0, e_due = 0;
    logic [31:0] e_res = 32'd0, e_hi = 32'd0, e_lo = 32'd0;
    logic        e_ovf = 1'b0, e_dbz = 1'b0, e_ill = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                     input logic [4:0] sh, output logic [31:0] res, output logic [31:0] hi,
                                     output logic [31:0] lo, output logic ovf, output logic dbz,
                                     output logic ill, output logic multi);
        longint s, q, r;
        logic [63:0] p;
        logic signed [31:0] sb;
        res = 32'd0; hi = m_hi; lo = m_lo; ovf = 1'b0; dbz = 1'b0; ill = 1'b0; multi = 1'b0;
        sb = b;
        case (op)
            5'd0:  res = a & b;
            5'd1:  res = a | b;
            5'd2:  begin res = a + b; s = longint'($signed(a)) + longint'($signed(b)); ovf = (s != longint'($signed(res))); end
            5'd3:  begin res = a - b; s = longint'($signed(a)) - longint'($signed(b)); ovf = (s != longint'($signed(res))); end
            5'd4:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd5:  res = ~(a | b);
            5'd6:  res = a ^ b;
            5'd7:  res = b << sh;
            5'd8:  res = b >> sh;
            5'd9:  res = sb >>> sh;
            5'd10: res = {b[15:0], 16'h0000};
            5'd11: begin multi = 1'b1; p = longint'($signed(a)) * longint'($signed(b)); hi = p[63:32]; lo = p[31:0]; end
            5'd12: begin multi = 1'b1; p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
            5'd13: begin
                if (b == 32'd0) dbz = 1'b1;
                else begin
                    multi = 1'b1;
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    lo = q[31:0]; hi = r[31:0];
                end
            end
            5'd14: begin
                if (b == 32'd0) dbz = 1'b1;
                else begin multi = 1'b1; lo = a / b; hi = a % b; end
            end
            5'd15: res = m_hi;
            5'd16: res = m_lo;
            default: ill = 1'b1;
        endcase
        if (multi) res = lo;
    endfunction

    // model timeline: done due on a known edge, busy over the 32 iteration cycles
    always @(posedge clk) begin
        cyc++;
        m_done = 1'b0;
        if (pend && cyc == e_due) begin
            m_result = e_res; m_zero = (e_res == 32'd0); m_ovf = e_ovf; m_dbz = e_dbz;
            m_ill = e_ill; m_hi = e_hi; m_lo = e_lo; m_done = 1'b1; pend = 1'b0;
        end
    end

    always @(negedge clk) begin
        bit eb;
        eb = pend && e_multi && (cyc >= e_e0) && (cyc <= e_e0 + 31);
        chk("done",      32'(done),      32'(m_done));
        chk("busy",      32'(busy),      32'(eb));
        chk("result",    result,         m_result);
        chk("zero",      32'(zero),      32'(m_zero));
        chk("overflow",  32'(overflow),  32'(m_ovf));
        chk("divByZero", 32'(divByZero), 32'(m_dbz));
        chk("illegalOp", 32'(illegalOp), 32'(m_ill));
    end

    task automatic arm_model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        logic [31:0] r, h, l;
        logic o, d, i, mu;
        model_op(op, a, b, sh, r, h, l, o, d, i, mu);
        e_res = r; e_hi = h; e_lo = l; e_ovf = o; e_dbz = d; e_ill = i; e_multi = mu;
        e_e0 = cyc + 1;
        e_due = mu ? cyc + 34 : cyc + 1;
        pend = 1'b1;
    endtask

    // called at posedge+1; returns edges from the start edge to the done edge
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] sh, input bit hold_start, output int lat);
        arm_model(op, a, b, sh);
        aLUControl = op; operandA = a; operandB = b; shamt = sh; start = 1'b1;
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                aLUControl = 5'd2; operandA = $urandom; operandB = $urandom; shamt = 5'($urandom);
                start = hold_start;
            end
            if (done) begin lat = k; break; end
        end
        start = 1'b0;
        if (lat < 0) begin
            n_checks++; n_fail++;
            $display("FAIL timeout: no done for op %0d within 40 cycles", op);
        end
    endtask

    task automatic reset_model();
        pend = 1'b0; m_hi = 32'd0; m_lo = 32'd0; m_result = 32'd0; m_zero = 1'b1;
        m_ovf = 1'b0; m_dbz = 1'b0; m_ill = 1'b0; m_done = 1'b0;
    endtask

    logic [4:0]  v_op [12] = '{5'd0, 5'd1, 5'd5, 5'd6, 5'd7, 5'd8, 5'd10, 5'd3, 5'd12, 5'd13, 5'd13, 5'd11};
    logic [31:0] v_a  [12] = '{32'hF0F0_1234, 32'h0F00_00FF, 32'h1234_0000, 32'hAAAA_5555, 32'h0, 32'h0,
                               32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0007, 32'hFFFF_FFFB};
    logic [31:0] v_b  [12] = '{32'hFF00_FF00, 32'h00F0_0F00, 32'h0000_5678, 32'h5A5A_5A5A, 32'h8000_0001, 32'h8000_0001,
                               32'h0000_ABCD, 32'h0000_0001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFF9};
    logic [4:0]  v_sh [12] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd3, 5'd31, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};

    initial begin
        int lat;
        repeat (2) @(posedge clk);
        #1;
        // start held high across reset release must be ignored
        aLUControl = 5'd2; operandA = 32'd1; operandB = 32'd1; start = 1'b1; reset_n = 1'b1;
        @(posedge clk); #1;
        chk("start_at_release", 32'(done), 32'd0);
        start = 1'b0;

        run_op(5'd2, 32'h7FFF_FFFF, 32'h0000_0001, 5'd0, 1'b0, lat);
        chk("add_latency", lat, 32'd0);
        chk("add_result", result, 32'h8000_0000);
        chk("add_overflow", 32'(overflow), 32'd1);
        chk("add_zero", 32'(zero), 32'd0);
        run_op(5'd3, 32'd5, 32'd5, 5'd0, 1'b0, lat);
        chk("sub_result", result, 32'd0);
        chk("sub_zero", 32'(zero), 32'd1);
        run_op(5'd4, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0, lat);
        chk("slt_result", result, 32'd1);
        run_op(5'd9, 32'd0, 32'h8000_0000, 5'd4, 1'b0, lat);
        chk("sra_result", result, 32'hF800_0000);

        run_op(5'd11, 32'hFFFF_FFFE, 32'd3, 5'd0, 1'b1, lat);
        chk("mult_latency", lat, 32'd33);
        chk("mult_lo", result, 32'hFFFF_FFFA);
        run_op(5'd15, 32'd0, 32'd0, 5'd0, 1'b0, lat);
        chk("mult_hi", result, 32'hFFFF_FFFF);

        run_op(5'd14, 32'd100, 32'd7, 5'd0, 1'b0, lat);
        chk("divu_latency", lat, 32'd33);
        chk("divu_lo", result, 32'd14);
        run_op(5'd15, 32'd0, 32'd0, 5'd0, 1'b0, lat);
        chk("divu_hi", result, 32'd2);
        run_op(5'd13, 32'hFFFF_FFF9, 32'd2, 5'd0, 1'b0, lat);
        chk("div_lo", result, 32'hFFFF_FFFD);
        run_op(5'd15, 32'd0, 32'd0, 5'd0, 1'b0, lat);
        chk("div_hi", result, 32'hFFFF_FFFF);

        run_op(5'd13, 32'd9, 32'd0, 5'd0, 1'b0, lat);
        chk("div0_latency", lat, 32'd0);
        chk("div0_flag", 32'(divByZero), 32'd1);
        chk("div0_result", result, 32'd0);
        run_op(5'd15, 32'd0, 32'd0, 5'd0, 1'b0, lat);
        chk("div0_hi_kept", result, 32'hFFFF_FFFF);
        run_op(5'd16, 32'd0, 32'd0, 5'd0, 1'b0, lat);
        chk("div0_lo_kept", result, 32'hFFFF_FFFD);
        run_op(5'd31, 32'd3, 32'd4, 5'd0, 1'b0, lat);
        chk("illegal_flag", 32'(illegalOp), 32'd1);
        chk("illegal_result", result, 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_op(v_op[i], v_a[i], v_b[i], v_sh[i], 1'b0, lat);
            if (v_op[i] >= 5'd11) begin
                run_op(5'd15, 32'd0, 32'd0, 5'd0, 1'b0, lat);
            end
        end

        // reset in the middle of a MULTU
        arm_model(5'd12, 32'h1234_5678, 32'h9ABC_DEF0, 5'd0);
        aLUControl = 5'd12; operandA = 32'h1234_5678; operandB = 32'h9ABC_DEF0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        reset_n = 1'b0;
        reset_model();
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (2) begin @(posedge clk); #1; end
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_op(5'd16, 32'd0, 32'd0, 5'd0, 1'b0, lat);
        chk("abort_lo", result, 32'd0);
        run_op(5'd15, 32'd0, 32'd0, 5'd0, 1'b0, lat);
        chk("abort_hi", result, 32'd0);

        repeat (2) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
